// File: rtl/ic_pkg.sv
// ic_pkg -- shared icache fill types and geometry.
//   ADDR_BITS      : byte address width
//   LG_BYTES       : log2 of line size in bytes (16-byte line)
//   WORDS_PER_LINE : halfwords per line
//   ic_fill_t      : one fill beat, element i = halfword i of the half-line
//   ic_fill_state_t: line-fill responder FSM states
package ic_pkg;
  localparam int ADDR_BITS      = 32;
  localparam int LG_BYTES       = 4;
  localparam int WORDS_PER_LINE = 8;
  localparam int HALF_WORDS     = WORDS_PER_LINE / 2;
  localparam int LINE_BITS      = ADDR_BITS - LG_BYTES;

  typedef logic [HALF_WORDS-1:0][15:0] ic_fill_t;

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN} ic_fill_state_t;
endpackage

// File: rtl/ic_fill_buf.sv
// ic_fill_buf -- 8 x 16b line buffer with per-entry valid bits.
//   clk, rst_n          : clock, async active-low reset
//   clr                 : drop all valid bits (line finished)
//   wr_en/wr_idx/wr_data: write one halfword at its position in the line
//   rd_half             : which half-line rd_data shows
//   rd_data             : four halfwords of the selected half
//   half_done[h]        : all four halfwords of half h are valid
module ic_fill_buf
  import ic_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr,
  input  logic        wr_en,
  input  logic [2:0]  wr_idx,
  input  logic [15:0] wr_data,
  input  logic        rd_half,
  output ic_fill_t    rd_data,
  output logic [1:0]  half_done
);
  logic [15:0] mem [WORDS_PER_LINE];
  logic        vld [WORDS_PER_LINE];

  for (genvar e = 0; e < WORDS_PER_LINE; e++) begin : g_ent
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        mem[e] <= '0;
        vld[e] <= 1'b0;
      end else if (clr) begin
        vld[e] <= 1'b0;
      end else if (wr_en && wr_idx == 3'(e)) begin
        mem[e] <= wr_data;
        vld[e] <= 1'b1;
      end
    end
  end

  for (genvar h = 0; h < 2; h++) begin : g_half
    assign half_done[h] = vld[4*h] & vld[4*h+1] & vld[4*h+2] & vld[4*h+3];
  end

  for (genvar i = 0; i < HALF_WORDS; i++) begin : g_rd
    assign rd_data[i] = mem[{rd_half, 2'(i)}];
  end
endmodule

// File: rtl/ic_fill_resp.sv
// ic_fill_resp -- icache line-fill responder.
// Takes one miss request, issues the 8 halfword reads of the line to memory
// (bounded by MAX_OUTSTANDING in flight), collects returns in ic_fill_buf and
// hands the line to the icache as two 4-halfword beats.
//   req_valid/req_ready/req_addr : miss request (halfword address)
//   fill_valid/fill_ready        : beat handshake
//   fill_data/fill_half/fill_last: beat payload, line half, final beat
//   mem_rd/mem_addr/mem_ack      : read issue (issued when mem_rd && mem_ack)
//   mem_rvalid/mem_rdata         : in-order read return, no backpressure
// Build option: define IC_FILL_CWF_EN for critical-word-first order; without
// it the line is always fetched from halfword 0 and delivered half 0 first.
module ic_fill_resp
  import ic_pkg::*;
#(
  parameter int MAX_OUTSTANDING = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [ADDR_BITS-1:1] req_addr,
  output logic                 fill_valid,
  input  logic                 fill_ready,
  output ic_fill_t             fill_data,
  output logic                 fill_half,
  output logic                 fill_last,
  output logic                 mem_rd,
  output logic [ADDR_BITS-1:1] mem_addr,
  input  logic                 mem_ack,
  input  logic                 mem_rvalid,
  input  logic [15:0]          mem_rdata
);
  localparam logic [3:0] MAX_OS = 4'(MAX_OUTSTANDING);

  ic_fill_state_t       state, state_nxt;
  logic [LINE_BITS-1:0] line_q;
  logic [2:0]           start_hw, start_q;
  logic [3:0]           issue_cnt, os_cnt;
  logic [2:0]           ret_cnt;
  logic                 beat_q;
  logic                 accept, issue, ret, beat_hs, last_hs, cur_half;
  ic_fill_t             buf_data;
  logic [1:0]           half_done;

`ifdef IC_FILL_CWF_EN
  assign start_hw = req_addr[LG_BYTES-1:1];
`else
  logic unused_start;
  assign unused_start = ^req_addr[LG_BYTES-1:1];
  assign start_hw     = '0;
`endif

  assign accept   = req_valid && req_ready;
  assign issue    = mem_rd && mem_ack;
  // returns with nothing in flight are strays from an abandoned line
  assign ret      = mem_rvalid && (os_cnt != '0);
  // first beat is the half holding the start halfword
  assign cur_half = start_q[2] ^ beat_q;
  assign beat_hs  = fill_valid && fill_ready;
  assign last_hs  = beat_hs && beat_q;
  // 3-bit sum wraps the read sequence inside the line
  assign mem_addr = {line_q, 3'(start_q + issue_cnt[2:0])};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (req_valid) state_nxt = FETCH;
      FETCH:   if (issue && issue_cnt == 4'd7) state_nxt = DRAIN;
      DRAIN:   if (last_hs) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    req_ready  = (state == IDLE);
    mem_rd     = (state == FETCH) && (os_cnt < MAX_OS);
    fill_valid = (state != IDLE) && half_done[cur_half];
    fill_data  = fill_valid ? buf_data : '0;
    fill_half  = fill_valid & cur_half;
    fill_last  = fill_valid & beat_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      line_q    <= '0;
      start_q   <= '0;
      issue_cnt <= '0;
      ret_cnt   <= '0;
      os_cnt    <= '0;
      beat_q    <= 1'b0;
    end else begin
      if (accept) begin
        line_q    <= req_addr[ADDR_BITS-1:LG_BYTES];
        start_q   <= start_hw;
        issue_cnt <= '0;
        ret_cnt   <= '0;
        beat_q    <= 1'b0;
      end
      if (issue) issue_cnt <= issue_cnt + 4'd1;
      if (ret)   ret_cnt   <= ret_cnt + 3'd1;
      case ({issue, ret})
        2'b10:   os_cnt <= os_cnt + 4'd1;
        2'b01:   os_cnt <= os_cnt - 4'd1;
        default: ;
      endcase
      // toggles back to 0 on the last beat
      if (beat_hs) beat_q <= ~beat_q;
    end
  end

  // returns are in issue order, so the k-th return lands at start + k
  ic_fill_buf u_buf (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (last_hs),
    .wr_en     (ret),
    .wr_idx    (3'(start_q + ret_cnt)),
    .wr_data   (mem_rdata),
    .rd_half   (cur_half),
    .rd_data   (buf_data),
    .half_done (half_done)
  );
endmodule

// File: tb/tb_ic_fill_resp.sv
module tb_ic_fill_resp;
  import ic_pkg::*;

  localparam int MAX_OS = 2;
`ifdef IC_FILL_CWF_EN
  localparam bit CWF = 1'b1;
`else
  localparam bit CWF = 1'b0;
`endif

  logic                 clk = 1'b0, rst_n = 1'b0;
  logic                 req_valid = 1'b0, fill_ready = 1'b0;
  logic                 mem_ack = 1'b0, mem_rvalid = 1'b0;
  logic [ADDR_BITS-1:1] req_addr = '0;
  logic [15:0]          mem_rdata = '0;
  logic                 req_ready, fill_valid, fill_half, fill_last, mem_rd;
  ic_fill_t             fill_data;
  logic [ADDR_BITS-1:1] mem_addr;

  ic_fill_resp #(.MAX_OUTSTANDING(MAX_OS)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .fill_valid(fill_valid), .fill_ready(fill_ready), .fill_data(fill_data),
    .fill_half(fill_half), .fill_last(fill_last),
    .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_ack(mem_ack),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    ic_fill_t data;
    logic     half;
    logic     last;
  } beat_t;

  typedef struct {
    logic [31:0] baddr;
    int          lat;
    bit          ack_rand;
    int          stall;
    logic [31:0] first_cwf;
    logic [31:0] first_lin;
    logic        half_cwf;
  } vec_t;

  int n_cmp = 0, n_bad = 0;
  logic [ADDR_BITS-1:1] exp_addr[$];
  beat_t                exp_beat[$];
  logic [ADDR_BITS-1:1] mq_addr[$];
  int                   mq_due[$];
  int   lat = 1, stall_left = 0, stray_left = 0, n_issued = 0, last_hs_cyc = -10;
  bit   ack_rand = 1'b0;
  logic [31:0] first_addr;
  logic        first_half;

  function automatic logic [15:0] mdata(input logic [ADDR_BITS-1:1] a);
    return a[16:1] * 16'd3 + 16'h1357;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic fail_now(input string nm);
    n_cmp++;
    n_bad++;
    $display("FAIL %s", nm);
  endtask

  task automatic push_exp(input logic [31:0] baddr);
    logic [2:0]           s;
    logic [LINE_BITS-1:0] ln;
    beat_t                b;
    s  = CWF ? baddr[3:1] : 3'd0;
    ln = baddr[31:4];
    for (int k = 0; k < 8; k++) exp_addr.push_back({ln, 3'(s + 3'(k))});
    for (int bt = 0; bt < 2; bt++) begin
      b.half = s[2] ^ (bt == 1);
      b.last = (bt == 1);
      for (int i = 0; i < 4; i++) b.data[i] = mdata({ln, b.half, 2'(i)});
      exp_beat.push_back(b);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_req_ready"}, req_ready, 1);
    chk({tag, "_fill_valid"}, fill_valid, 0);
    chk({tag, "_fill_last"}, fill_last, 0);
    chk({tag, "_fill_half"}, fill_half, 0);
    chk({tag, "_fill_data"}, fill_data, 0);
    chk({tag, "_mem_rd"}, mem_rd, 0);
    chk({tag, "_mem_addr"}, mem_addr, 0);
  endtask

  // call right after a negedge
  task automatic send_req(input logic [31:0] baddr, input bit hold);
    bit ok = 1'b0;
    req_addr  = baddr[31:1];
    req_valid = 1'b1;
    for (int n = 0; n < 50; n++) begin
      if (req_ready) begin push_exp(baddr); ok = 1'b1; break; end
      @(negedge clk);
    end
    if (!ok) fail_now("req_accept_timeout");
    @(negedge clk);
    if (!hold) req_valid = 1'b0;
  endtask

  task automatic wait_idle();
    bit ok = 1'b0;
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      if (exp_beat.size() == 0 && exp_addr.size() == 0 && req_ready) begin ok = 1'b1; break; end
    end
    if (!ok) fail_now("line_done_timeout");
  endtask

  // memory model: in-order, fixed latency, optional random ack and stray returns
  always @(negedge clk) begin
    int mq_before;
    if (!rst_n) begin
      mq_addr.delete();
      mq_due.delete();
      mem_rvalid = 1'b0;
      mem_ack    = 1'b0;
    end else begin
      mq_before  = mq_addr.size();
      mem_rvalid = 1'b0;
      mem_rdata  = '0;
      if (mq_due.size() > 0 && mq_due[0] <= cyc) begin
        mem_rvalid = 1'b1;
        mem_rdata  = mdata(mq_addr[0]);
        void'(mq_addr.pop_front());
        void'(mq_due.pop_front());
      end else if (stray_left > 0) begin
        mem_rvalid = 1'b1;
        mem_rdata  = 16'hDEAD;
        stray_left--;
      end
      if (!req_ready) chk("mem_rd", mem_rd, exp_addr.size() > 0 && mq_before < MAX_OS);
      mem_ack = ack_rand ? 1'($urandom_range(0, 1)) : 1'b1;
      if (mem_rd && mem_ack) begin
        if (exp_addr.size() == 0) fail_now("spurious_mem_rd");
        else begin
          if (exp_addr.size() == 8) first_addr = {mem_addr, 1'b0};
          chk("mem_addr", mem_addr, exp_addr.pop_front());
        end
        mq_addr.push_back(mem_addr);
        mq_due.push_back(cyc + lat);
        n_issued++;
      end
    end
  end

  // fill sink: optional stall on the first beat, scoreboard compare on handshake
  always @(negedge clk) begin
    beat_t b;
    if (!rst_n) fill_ready = 1'b0;
    else if (fill_valid) begin
      if (exp_beat.size() == 0) begin
        fail_now("spurious_fill_valid");
        fill_ready = 1'b1;
      end else if (stall_left > 0) begin
        fill_ready = 1'b0;
        stall_left--;
        chk("stall_data", fill_data, exp_beat[0].data);
        chk("stall_half", fill_half, exp_beat[0].half);
        chk("stall_req_ready", req_ready, 0);
      end else begin
        fill_ready = 1'b1;
        b = exp_beat.pop_front();
        if (!b.last) first_half = fill_half;
        chk("fill_data", fill_data, b.data);
        chk("fill_half", fill_half, b.half);
        chk("fill_last", fill_last, b.last);
        if (fill_last) last_hs_cyc = cyc;
      end
    end else fill_ready = 1'b0;
  end

  initial begin
    #400000;
    $display("FAIL watchdog");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[6];
    int   acc_cyc;
    bit   ok;
    vecs[0] = '{32'h0001_234A, 1, 1'b0, 0,  32'h0001_234A, 32'h0001_2340, 1'b1};
    vecs[1] = '{32'h0001_2340, 1, 1'b0, 0,  32'h0001_2340, 32'h0001_2340, 1'b0};
    vecs[2] = '{32'h0000_ABCE, 5, 1'b0, 0,  32'h0000_ABCE, 32'h0000_ABC0, 1'b1};
    vecs[3] = '{32'h0000_FFF6, 3, 1'b1, 0,  32'h0000_FFF6, 32'h0000_FFF0, 1'b0};
    vecs[4] = '{32'h0001_234A, 2, 1'b0, 10, 32'h0001_234A, 32'h0001_2340, 1'b1};
    vecs[5] = '{32'h0007_6548, 1, 1'b1, 0,  32'h0007_6548, 32'h0007_6540, 1'b1};

    repeat (3) @(negedge clk);
    chk_reset("rst");
    #2 rst_n = 1'b1;
    @(negedge clk);
    chk_reset("post_rst");

    foreach (vecs[v]) begin
      lat        = vecs[v].lat;
      ack_rand   = vecs[v].ack_rand;
      stall_left = vecs[v].stall;
      first_addr = '1;
      first_half = 1'bx;
      send_req(vecs[v].baddr, 1'b0);
      wait_idle();
      chk("first_mem_addr", first_addr, CWF ? vecs[v].first_cwf : vecs[v].first_lin);
      chk("first_beat_half", first_half, CWF ? vecs[v].half_cwf : 1'b0);
    end

    // reset in the middle of a fetch, then stray returns
    lat = 1; ack_rand = 1'b0; n_issued = 0;
    send_req(32'h0002_468C, 1'b0);
    for (int n = 0; n < 50 && n_issued < 3; n++) @(negedge clk);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 chk_reset("mid_rst");
    exp_addr.delete();
    exp_beat.delete();
    stall_left = 0;
    @(negedge clk);
    #2 rst_n = 1'b1;
    stray_left = 2;
    repeat (3) @(negedge clk);
    chk_reset("stray");
    send_req(32'h0005_555C, 1'b0);
    wait_idle();

    // back-to-back with req_valid held high
    lat = 1;
    send_req(32'h0003_1002, 1'b1);
    req_addr = 31'(32'h0004_200E >> 1);
    ok = 1'b0;
    acc_cyc = 0;
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      if (req_ready) begin acc_cyc = cyc; push_exp(32'h0004_200E); ok = 1'b1; break; end
    end
    if (!ok) fail_now("b2b_accept_timeout");
    else chk("b2b_gap", acc_cyc - last_hs_cyc, 1);
    @(negedge clk);
    req_valid = 1'b0;
    wait_idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
